seq_scan_sched: RTL and testbench
=================================

# seq_scan_sched

Round-robin scheduler that shares one bit-serial Mealy sequence detector among NREQ parallel-word requesters. Accepts one WORD_W-bit word at a time, shifts it MSB-first through the detector one bit per clock, and reports the number of overlapping pattern matches found in that word. Sits between the word-producing requesters and the serial detection datapath, so no requester needs its own detector.

## Interface

- `NREQ`, 4: number of requesters; must be at least 2.
- `WORD_W`, 8: word width, which is also the number of shift cycles per job.
- `PAT_W`, 4: pattern length; must satisfy 2 ≤ PAT_W ≤ WORD_W.
- `PAT`, 4'b1011: pattern to detect. Its MSB is the first bit received.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `req`  in  NREQ: per-requester request. The requester holds it high until its grant.
- `word_in`  in  NREQ*WORD_W: requester i's word is in slice [i*WORD_W +: WORD_W]. It must be stable while req[i] is high.
- `grant`  out  NREQ: one-hot, one-cycle pulse meaning the word was captured.
- `busy`  out  1: high when the state is not IDLE.
- `match_valid`  out  1: one-cycle pulse; the result is valid.
- `match_id`  out  $clog2(NREQ): index of the requester that owns the result.
- `match_cnt`  out  $clog2(WORD_W+1): number of matches in the word.

## Operation

- The FSM has three states: IDLE, SHIFT, REPORT.
- **IDLE:**
  - With req ≠ 0, the clock edge selects a winner and transitions to SHIFT. At that edge the block:
    - loads the winner's word into the shift register;
    - stores the winner index;
    - clears the bit counter, the match count and the detector history;
    - updates the round-robin pointer to the winner;
    - sets grant[winner] for the next cycle.
  - With req = 0, the block stays in IDLE.
- **Arbitration:** search from ptr+1 upward, wrapping modulo NREQ. The first set bit wins. ptr resets to NREQ-1, so req[0] wins the first contest.
- **SHIFT:**
  - Each cycle the block presents the shift-register MSB to the detector, shifts left, and increments the bit counter.
  - When the detector output is 1, match_cnt is incremented.
  - After the WORD_W-th bit, the next state is REPORT.
- **REPORT:** match_valid = 1 for one cycle, with match_id and match_cnt stable. The next state is IDLE.
- **Detector:**
  - Mealy: out = ({hist, bit} == PAT) && (bits_seen ≥ PAT_W-1). hist holds the last PAT_W-1 bits.
  - Overlapping matches count.
  - No match spans two words, because history is cleared per job.
- **Width:** match_cnt never exceeds WORD_W-PAT_W+1, so no saturation is needed.
- **Holding values:** match_id and match_cnt keep their last values outside REPORT. Consumers use them only when match_valid is high.
- **Requests during SHIFT and REPORT** are ignored and held. They are arbitrated on the next IDLE edge.
- **Dropped request:** if req[i] drops without a grant, it is simply not served. Nothing is latched.

## Timing

- **Reset** (reset = 0 at an edge), including mid-job:
  - state = IDLE, grant = 0, busy = 0, match_valid = 0, match_id = 0, match_cnt = 0, ptr = NREQ-1;
  - the shift register, history and counters are cleared;
  - an in-flight job is discarded with no REPORT.
- **Capture edge = cycle 0.**
  - grant and busy are high in cycle 1.
  - SHIFT runs in cycles 1..WORD_W.
  - match_valid is high in cycle WORD_W+1.
  - IDLE is reached in cycle WORD_W+2. The earliest next capture is at the edge ending cycle WORD_W+2.
- **Period:** one job every WORD_W+2 cycles under continuous requests.
- **Requester rule:** deassert req at the edge ending the grant cycle, then present the next word and re-assert. The next capture can never occur before WORD_W+2 cycles, so a grant-cycle requester is never double-served.
- **Simultaneous events:**
  - The REPORT of one job and new request arrivals: the request waits for IDLE.
  - Reset together with req: reset wins.

## Structure

- **Package `seq_sched_pkg`:**
  - state enum typedef (IDLE, SHIFT, REPORT);
  - default PAT/PAT_W constants;
  - a width function for match_cnt.
- **Sub-module `seq_detect_core`:**
  - ports: clock, reset, clr, bit_vld, bit_in, out;
  - parameterised by PAT and PAT_W;
  - Mealy output, history register, bits_seen counter.
- **Top** holds the arbiter, FSM, shift register, counters and output registers.

## Test plan

- **Reset then single job:** release reset; req = 0001, word0 = 8'b10111011 → grant = 0001 one cycle after capture, match_valid 9 cycles after capture, match_id = 0, match_cnt = 2.
- **Overlap:** word = 8'b10110110 → match_cnt = 2. Word 8'h00 → 0; 8'hFF → 0; 8'b01011000 → 1.
- **Round-robin:** req = 1111 held, re-asserting after each grant → grant order 0, 1, 2, 3, 0, with grants 10 cycles apart.
- **Priority after a pointer move:** after serving requester 2, req = 0011 → requester 3 is not requesting, so wrap gives grant 0 before 1.
- **Reset mid-SHIFT:** reset low in cycle 4 of a job → no match_valid; all outputs 0; busy = 0. The next req = 0100 is granted first with ptr = 3 → grant index 2, and the result is correct.
- **Requests during busy:** raise req[1] in the REPORT cycle of a job for req[0] → req[1] is captured at the edge ending the following IDLE cycle, with no lost or duplicate grant.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the round-robin serial scan scheduler.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int unsigned    DEF_PAT_W = 4;
    localparam logic [3:0]     DEF_PAT   = 4'b1011;

    // Bits needed to hold a match count of 0..word_w.
    function automatic int unsigned cnt_width(input int unsigned word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Bit-serial Mealy pattern detector with overlapping matches and a per-job clear.
module seq_detect_core #(
    parameter int unsigned        PAT_W = 4,
    parameter logic [PAT_W-1:0]   PAT   = 4'b1011
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_in,
    output logic out
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned SEEN_W = $clog2(PAT_W);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [SEEN_W-1:0] seen_q, seen_d;
    logic              full_c;

    // History is only trusted once PAT_W-1 real bits have been seen.
    assign full_c = (seen_q == SEEN_W'(HIST_W));
    assign out    = bit_vld && full_c && ({hist_q, bit_in} == PAT);

    // Next history/bit count; clear wins, the seen counter saturates.
    always_comb begin
        hist_d = hist_q;
        seen_d = seen_q;
        if (clr) begin
            hist_d = '0;
            seen_d = '0;
        end else if (bit_vld) begin
            hist_d = HIST_W'({hist_q, bit_in});
            if (!full_c) begin
                seen_d = seen_q + SEEN_W'(1);
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/seq_scan_sched.sv
// Round-robin scheduler feeding requester words MSB-first through one shared detector.
module seq_scan_sched
    import seq_sched_pkg::*;
#(
    parameter int unsigned        NREQ   = 4,
    parameter int unsigned        WORD_W = 8,
    parameter int unsigned        PAT_W  = DEF_PAT_W,
    parameter logic [PAT_W-1:0]   PAT    = DEF_PAT
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ*WORD_W-1:0]             word_in,
    output logic [NREQ-1:0]                    grant,
    output logic                               busy,
    output logic                               match_valid,
    output logic [$clog2(NREQ)-1:0]            match_id,
    output logic [cnt_width(WORD_W)-1:0]       match_cnt
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = cnt_width(WORD_W);
    localparam int unsigned BIT_W = $clog2(WORD_W);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                mvalid_q, mvalid_d;
    logic [IDX_W-1:0]    mid_q, mid_d;
    logic [CNT_W-1:0]    mcnt_q, mcnt_d;

    logic [IDX_W-1:0]    win_c;
    logic                any_c;
    int unsigned         cand_c;
    logic                det_c;

    seq_detect_core #(
        .PAT_W (PAT_W),
        .PAT   (PAT)
    ) u_det (
        .clock   (clock),
        .reset   (reset),
        .clr     (state_q == ST_IDLE),
        .bit_vld (state_q == ST_SHIFT),
        .bit_in  (shreg_q[WORD_W-1]),
        .out     (det_c)
    );

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        win_c  = '0;
        any_c  = 1'b0;
        cand_c = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = (32'(ptr_q) + k) % NREQ;
            if (!any_c && req[IDX_W'(cand_c)]) begin
                any_c = 1'b1;
                win_c = IDX_W'(cand_c);
            end
        end
    end

    // FSM next state, datapath updates and registered output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        run_cnt_d = run_cnt_q;
        grant_d   = '0;
        mvalid_d  = 1'b0;
        mid_d     = mid_q;
        mcnt_d    = mcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = word_in[win_c*WORD_W +: WORD_W];
                    owner_d   = win_c;
                    ptr_d     = win_c;
                    bitcnt_d  = '0;
                    run_cnt_d = '0;
                    grant_d   = NREQ'(1) << win_c;
                end
            end
            ST_SHIFT: begin
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + BIT_W'(1);
                if (det_c) begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
                // Last bit: publish the count including this bit's match.
                if (bitcnt_q == BIT_W'(WORD_W - 1)) begin
                    state_d  = ST_REPORT;
                    mvalid_d = 1'b1;
                    mid_d    = owner_q;
                    mcnt_d   = run_cnt_d;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDX_W'(NREQ - 1);
            owner_q   <= '0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            run_cnt_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            mvalid_q  <= 1'b0;
            mid_q     <= '0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            run_cnt_q <= run_cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            mvalid_q  <= mvalid_d;
            mid_q     <= mid_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign match_valid = mvalid_q;
    assign match_id    = mid_q;
    assign match_cnt   = mcnt_q;

endmodule

// File: tb/tb_seq_scan_sched.sv
// Directed bench for seq_scan_sched: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_seq_scan_sched;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WORD_W = 8;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] word_in;
    logic [3:0]  grant;
    logic        busy;
    logic        match_valid;
    logic [1:0]  match_id;
    logic [3:0]  match_cnt;

    int n_cmp;
    int n_bad;
    int cyc;

    typedef struct {
        logic [3:0] r;
        logic [7:0] w;
        int         id;
        int         cnt;
    } vec_t;

    vec_t tbl [13];

    seq_scan_sched #(
        .NREQ   (4),
        .WORD_W (8),
        .PAT_W  (4),
        .PAT    (4'b1011)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .word_in     (word_in),
        .grant       (grant),
        .busy        (busy),
        .match_valid (match_valid),
        .match_id    (match_id),
        .match_cnt   (match_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter used for latency measurements.
    initial cyc = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic wait_grant(output int gi, output int gc);
        int seen;
        seen = 0;
        gi   = -1;
        gc   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (grant != 4'b0) begin
                gi   = oh_idx(grant);
                gc   = cyc;
                seen = 1;
                break;
            end
        end
        check("grant_seen", seen, 1);
    endtask

    task automatic wait_valid(output int vc);
        int seen;
        seen = 0;
        vc   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (match_valid) begin
                vc   = cyc;
                seen = 1;
                break;
            end
        end
        check("valid_seen", seen, 1);
    endtask

    task automatic run_job(input logic [3:0] r, input logic [7:0] w, input int eid, input int ecnt);
        int gi, gc, vc, rc;
        @(posedge clock); #1;
        word_in = {4{w}};
        req     = r;
        rc      = cyc;
        wait_grant(gi, gc);
        check("grant_idx", gi, eid);
        check("grant_vec", 32'(grant), 32'(1) << eid);
        check("grant_lat", gc - rc, 1);
        check("busy_grant", 32'(busy), 1);
        @(posedge clock); #1;
        req = 4'b0;
        @(negedge clock);
        check("grant_pulse", 32'(grant), 0);
        wait_valid(vc);
        check("valid_lat", vc - gc, WORD_W);
        check("match_id", 32'(match_id), eid);
        check("match_cnt", 32'(match_cnt), ecnt);
        check("busy_report", 32'(busy), 1);
        @(negedge clock);
        check("valid_pulse", 32'(match_valid), 0);
        check("busy_idle", 32'(busy), 0);
        check("cnt_hold", 32'(match_cnt), ecnt);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        req   = 4'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        int gi, gc, vc, prev, nv, ng, exp_i;
        int rr_cnt [4];

        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        req     = 4'b0;
        word_in = 32'b0;

        tbl[0]  = '{4'b0001, 8'b10111011, 0, 2};
        tbl[1]  = '{4'b0001, 8'b10110110, 0, 2};
        tbl[2]  = '{4'b0010, 8'b00000000, 1, 0};
        tbl[3]  = '{4'b1000, 8'b11111111, 3, 0};
        tbl[4]  = '{4'b0001, 8'b01011000, 0, 1};
        tbl[5]  = '{4'b0100, 8'b11011011, 2, 2};
        tbl[6]  = '{4'b0011, 8'b01101011, 0, 1};
        tbl[7]  = '{4'b0010, 8'b10110111, 1, 2};
        tbl[8]  = '{4'b1001, 8'b10111011, 3, 2};
        tbl[9]  = '{4'b1110, 8'b00001011, 1, 1};
        tbl[10] = '{4'b0101, 8'b10110110, 2, 2};
        tbl[11] = '{4'b1000, 8'b00000101, 3, 0};
        tbl[12] = '{4'b0001, 8'b10000000, 0, 0};

        // Reset values.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(match_valid), 0);
        check("rst_id", 32'(match_id), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Vector table: arbitration order and match counts.
        for (int i = 0; i < 13; i++) begin
            run_job(tbl[i].r, tbl[i].w, tbl[i].id, tbl[i].cnt);
        end

        // Reset in cycle 4 of a job for requester 0, with a request pending.
        @(posedge clock); #1;
        word_in = {4{8'b10111011}};
        req     = 4'b0001;
        wait_grant(gi, gc);
        check("mid_grant", gi, 0);
        @(posedge clock); #1;
        req = 4'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        req   = 4'b0010;
        @(posedge clock); #1;
        reset = 1'b1;
        req   = 4'b0;
        @(negedge clock);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(match_valid), 0);
        check("mid_rst_id", 32'(match_id), 0);
        check("mid_rst_cnt", 32'(match_cnt), 0);
        nv = 0;
        ng = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (match_valid) nv++;
            if (grant != 4'b0) ng++;
        end
        check("mid_no_valid", nv, 0);
        check("mid_no_grant", ng, 0);
        run_job(4'b0100, 8'b10111011, 2, 2);

        // Request raised during REPORT waits for the next IDLE edge.
        @(posedge clock); #1;
        word_in = {8'h00, 8'h00, 8'b10110110, 8'b01011000};
        req     = 4'b0001;
        wait_grant(gi, gc);
        check("bz_grant0", gi, 0);
        @(posedge clock); #1;
        req = 4'b0;
        wait_valid(vc);
        check("bz_cnt0", 32'(match_cnt), 1);
        req = 4'b0010;
        wait_grant(gi, gc);
        check("bz_grant1", gi, 1);
        check("bz_wait", gc - vc, 2);
        @(posedge clock); #1;
        req = 4'b0;
        wait_valid(vc);
        check("bz_id1", 32'(match_id), 1);
        check("bz_cnt1", 32'(match_cnt), 2);
        ng = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (grant != 4'b0) ng++;
        end
        check("bz_no_dup", ng, 0);

        // Round robin with all requesters held after a fresh reset.
        do_reset();
        rr_cnt  = '{2, 0, 1, 2};
        word_in = {8'b10110110, 8'b01011000, 8'h00, 8'b10111011};
        @(posedge clock); #1;
        req  = 4'hF;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            exp_i = k % 4;
            wait_grant(gi, gc);
            check("rr_order", gi, exp_i);
            if (k > 0) check("rr_gap", gc - prev, WORD_W + 2);
            prev = gc;
            @(posedge clock); #1;
            if (gi >= 0) req[gi] = 1'b0;
            @(posedge clock); #1;
            if (gi >= 0) req[gi] = 1'b1;
            wait_valid(vc);
            check("rr_id", 32'(match_id), exp_i);
            check("rr_cnt", 32'(match_cnt), rr_cnt[exp_i]);
        end
        req = 4'b0;
        repeat (3) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
